lenet5_frame_sched: RTL

- Frame-level sequencer for the LeNet-5 inference core and its image pixel source. It issues the per-frame start pulse to the core and the image reader, and gates pixel streaming by pixel count.
- Waits for the core's prediction, captures the digit with a frame index, and repeats for a programmed number of frames.
- Replaces testbench-driven start/reset timing with a synthesizable controller; a per-frame watchdog flags hung frames.

---
 rtl/lenet5_frame_sched_pkg.sv | 8 +
 rtl/lenet5_frame_sched_if.sv | 29 ++
 rtl/lenet5_frame_sched_watchdog.sv | 18 +
 rtl/lenet5_frame_sched.sv | 100 ++++++++++
 4 files changed

// File: rtl/lenet5_frame_sched_pkg.sv
// lenet5_pkg: shared FSM states, digit width and image geometry for the LeNet-5 frame scheduler.
package lenet5_pkg;
    typedef enum logic [2:0] {IDLE, START, FEED, WAIT, NEXT, DONE} state_e;
    localparam int DIGIT_WIDTH = 4;
    localparam logic [DIGIT_WIDTH-1:0] TIMEOUT_DIGIT = '1;
    localparam int IMG_COLS = 32;
    localparam int IMG_PIXELS = IMG_COLS * IMG_COLS;
endpackage

// File: rtl/lenet5_frame_sched_if.sv
// lenet5_frame_sched_if: run/start, pixel and result signals of the frame scheduler.
// LENET5_SCHED_HIST_EN adds the histogram read port.
interface lenet5_frame_sched_if #(
    parameter int DW = lenet5_pkg::DIGIT_WIDTH,
    parameter int IW = 5
);
    logic run, start_n, core_validin, pix_en, core_validout;
    logic [DW-1:0] core_out, res_digit;
    logic [IW-1:0] res_idx;
    logic res_valid, busy, done, timeout_err;
`ifdef LENET5_SCHED_HIST_EN
    logic [3:0] hist_sel;
    logic [7:0] hist_cnt;
`endif
    modport master (
        input  run, core_validin, core_validout, core_out,
        output start_n, pix_en, res_valid, res_digit, res_idx, busy, done, timeout_err
`ifdef LENET5_SCHED_HIST_EN
        , input hist_sel, output hist_cnt
`endif
    );
    modport slave (
        output run, core_validin, core_validout, core_out,
        input  start_n, pix_en, res_valid, res_digit, res_idx, busy, done, timeout_err
`ifdef LENET5_SCHED_HIST_EN
        , output hist_sel, input hist_cnt
`endif
    );
endinterface

// File: rtl/lenet5_frame_sched_watchdog.sv
// lenet5_sched_watchdog: saturating cycle counter that flags the LIMIT-th enabled cycle since clear.
module lenet5_sched_watchdog #(
    parameter int LIMIT = 30000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else if (clr) cnt_q <= '0;
        else if (en && cnt_q != W'(LIMIT)) cnt_q <= cnt_q + W'(1);
    assign expire = en && cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/lenet5_frame_sched.sv
// lenet5_frame_sched: per-frame start, pixel gating, result capture and watchdog for the LeNet-5 core.
// LENET5_SCHED_HIST_EN adds a per-digit result histogram.
module lenet5_frame_sched
    import lenet5_pkg::*;
#(
    parameter int NUM_FRAMES       = 24,
    parameter int PIXELS_PER_FRAME = 1024,
    parameter int TIMEOUT_CYCLES   = 30000,
    parameter int DIGIT_WIDTH      = 4
) (
    input logic clk,
    input logic rst,
    lenet5_frame_sched_if.master bus
);
    localparam int IW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1;
    localparam int PW = $clog2(PIXELS_PER_FRAME + 1);
    state_e state_q;
    logic [PW-1:0] pix_q;
    logic [IW-1:0] frame_q, res_idx_q;
    logic [DIGIT_WIDTH-1:0] res_digit_q;
    logic got_q, res_valid_q, timeout_q;
    logic active, launch, last_pix, capture, wd_exp, expire;

    assign active   = state_q == FEED || state_q == WAIT;
    assign launch   = (state_q == IDLE || state_q == DONE) && bus.run;
    assign bus.pix_en = state_q == FEED && bus.core_validin && pix_q != PW'(PIXELS_PER_FRAME);
    assign last_pix = bus.pix_en && pix_q == PW'(PIXELS_PER_FRAME - 1);
    assign capture  = active && bus.core_validout && !got_q;
    // a real prediction arriving on the expiry cycle takes priority over the timeout
    assign expire   = wd_exp && !got_q && !bus.core_validout;

    lenet5_sched_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
        .clk(clk), .rst_n(rst), .clr(state_q == START), .en(active), .expire(wd_exp)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q     <= IDLE;
            pix_q       <= '0;
            frame_q     <= '0;
            got_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_digit_q <= '0;
            res_idx_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            res_valid_q <= capture || expire;
            if (capture || expire) begin
                res_digit_q <= capture ? bus.core_out : '1;
                res_idx_q   <= frame_q;
                got_q       <= 1'b1;
            end
            if (expire) timeout_q <= 1'b1;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= launch ? START : IDLE;
                    if (launch) begin
                        frame_q   <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                START: begin
                    pix_q   <= '0;
                    got_q   <= 1'b0;
                    state_q <= FEED;
                end
                FEED: begin
                    if (bus.pix_en) pix_q <= pix_q + PW'(1);
                    if (expire) state_q <= NEXT;
                    else if (last_pix) state_q <= (got_q || capture) ? NEXT : WAIT;
                end
                WAIT: if (capture || expire) state_q <= NEXT;
                NEXT: begin
                    state_q <= frame_q == IW'(NUM_FRAMES - 1) ? DONE : START;
                    if (frame_q != IW'(NUM_FRAMES - 1)) frame_q <= frame_q + IW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end

    assign bus.start_n     = state_q != START;
    assign bus.busy        = state_q != IDLE && state_q != DONE;
    assign bus.done        = state_q == DONE;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_digit   = res_digit_q;
    assign bus.res_idx     = res_idx_q;
    assign bus.timeout_err = timeout_q;

`ifdef LENET5_SCHED_HIST_EN
    logic [7:0] hist_q [10];
    logic [3:0] dig;
    assign dig = bus.core_out[3:0];
    always_ff @(posedge clk or negedge rst)
        if (!rst) for (int i = 0; i < 10; i++) hist_q[i] <= '0;
        else if (launch) for (int i = 0; i < 10; i++) hist_q[i] <= '0;
        else if (capture && bus.core_out < DIGIT_WIDTH'(10) && hist_q[dig] != 8'hFF)
            hist_q[dig] <= hist_q[dig] + 8'd1;
    assign bus.hist_cnt = bus.hist_sel < 4'd10 ? hist_q[bus.hist_sel] : 8'd0;
`endif
endmodule
